// File: rtl/draw_glyph_cell.sv
// Renders one board-cell glyph (X, O or cursor box) onto the VGA pixel stream
// with a two-stage pipeline, frame-synchronous symbol latching, row reveal and blink.
module draw_glyph_cell #(
    parameter int SCALE         = 10,
    parameter int GLYPH_N       = 8,
    parameter int CW            = 8,
    parameter int BLINK_FRAMES  = 30,
    parameter int REVEAL_FRAMES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [9:0]      h_counter,
    input  logic [9:0]      v_counter,
    input  logic [9:0]      pos_x,
    input  logic [9:0]      pos_y,
    input  logic [1:0]      sym,
    input  logic            frame_tick,
    input  logic            blink_en,
    input  logic [3*CW-1:0] fg_rgb,
    input  logic [3*CW-1:0] bg_rgb,
    output logic [CW-1:0]   R,
    output logic [CW-1:0]   G,
    output logic [CW-1:0]   B,
    output logic            in_box,
    output logic            reveal_done
);

    localparam logic [10:0] SPAN      = 11'(GLYPH_N * SCALE);
    localparam logic [9:0]  SCALE10   = 10'(SCALE);
    localparam logic [9:0]  NM1       = 10'(GLYPH_N - 1);
    localparam logic [4:0]  ROWS_FULL = 5'(GLYPH_N);
    localparam logic [7:0]  RF        = 8'(REVEAL_FRAMES);
    localparam logic [15:0] BF_LAST   = 16'(BLINK_FRAMES - 1);
    localparam logic        ST_DONE   = 1'b0;
    localparam logic        ST_REVEAL = 1'b1;

    logic            hit_q, hit_d;
    logic [9:0]      dx_q, dx_d, dy_q, dy_d;
    logic [3*CW-1:0] rgb_q, rgb_d;
    logic            in_box_q;
    logic [1:0]      sym_q, sym_d;
    logic            state_q, state_d;
    logic [4:0]      rows_q, rows_d;
    logic [7:0]      sub_q, sub_d;
    logic [15:0]     blink_cnt_q, blink_cnt_d;
    logic            phase_q, phase_d;
    logic            done_q;

    // Pattern bit for glyph s at pattern cell (r,c); r,c are always < GLYPH_N here.
    function automatic logic glyph_bit(input logic [1:0] s, input logic [9:0] r, input logic [9:0] c);
        logic er;
        logic ec;
        logic b;
        er = (r == 10'd0) || (r == NM1);
        ec = (c == 10'd0) || (c == NM1);
        case (s)
            2'd1:    b = (c == r) || (c == NM1 - r);
            2'd2:    b = (er && !ec) || (ec && !er);
            2'd3:    b = er || ec;
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    // Stage 1: box hit test with the box end kept in 11 bits so it never wraps past 1023.
    always_comb begin
        logic h_hit;
        logic v_hit;
        h_hit = ({1'b0, h_counter} >= {1'b0, pos_x}) && ({1'b0, h_counter} < ({1'b0, pos_x} + SPAN));
        v_hit = ({1'b0, v_counter} >= {1'b0, pos_y}) && ({1'b0, v_counter} < ({1'b0, pos_y} + SPAN));
        hit_d = h_hit && v_hit;
        dx_d  = h_counter - pos_x;
        dy_d  = v_counter - pos_y;
    end

    // Stage 2: pattern lookup and colour select; DONE shows every row regardless of rows_q.
    always_comb begin
        logic [9:0] col_s;
        logic [9:0] row_s;
        logic [4:0] limit_s;
        logic       show_s;
        col_s   = dx_q / SCALE10;
        row_s   = dy_q / SCALE10;
        limit_s = (state_q == ST_DONE) ? ROWS_FULL : rows_q;
        show_s  = hit_q && glyph_bit(sym_q, row_s, col_s) && (row_s < {5'd0, limit_s})
                  && !(blink_en && phase_q);
        if (show_s) begin
            rgb_d = fg_rgb;
        end else begin
            rgb_d = bg_rgb;
        end
    end

    // Frame-rate state: symbol latch, reveal FSM and blink counter all advance only on frame_tick.
    always_comb begin
        sym_d       = sym_q;
        state_d     = state_q;
        rows_d      = rows_q;
        sub_d       = sub_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (frame_tick) begin
            if (blink_cnt_q == BF_LAST) begin
                blink_cnt_d = 16'd0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 16'd1;
            end
            if (sym != sym_q) begin
                sym_d = sym;
                sub_d = 8'd0;
                if ((sym == 2'd0) || (RF == 8'd0)) begin
                    state_d = ST_DONE;
                    rows_d  = ROWS_FULL;
                end else begin
                    state_d = ST_REVEAL;
                    rows_d  = 5'd0;
                end
            end else if (state_q == ST_REVEAL) begin
                if (sub_q + 8'd1 == RF) begin
                    sub_d  = 8'd0;
                    rows_d = rows_q + 5'd1;
                    if (rows_q + 5'd1 == ROWS_FULL) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_REVEAL;
                    end
                end else begin
                    sub_d = sub_q + 8'd1;
                end
            end else begin
                state_d = ST_DONE;
            end
        end else begin
            sym_d = sym_q;
        end
    end

    // Pipeline and frame-state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_q       <= 1'b0;
            dx_q        <= 10'd0;
            dy_q        <= 10'd0;
            rgb_q       <= '0;
            in_box_q    <= 1'b0;
            sym_q       <= 2'd0;
            state_q     <= ST_DONE;
            rows_q      <= 5'd0;
            sub_q       <= 8'd0;
            blink_cnt_q <= 16'd0;
            phase_q     <= 1'b0;
            done_q      <= 1'b1;
        end else begin
            hit_q       <= hit_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            rgb_q       <= rgb_d;
            in_box_q    <= hit_q;
            sym_q       <= sym_d;
            state_q     <= state_d;
            rows_q      <= rows_d;
            sub_q       <= sub_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            done_q      <= (state_d == ST_DONE);
        end
    end

    assign R           = rgb_q[3*CW-1:2*CW];
    assign G           = rgb_q[2*CW-1:CW];
    assign B           = rgb_q[CW-1:0];
    assign in_box      = in_box_q;
    assign reveal_done = done_q;

endmodule

// File: tb/tb_draw_glyph_cell.sv
// Randomised scoreboard bench for draw_glyph_cell; expected pixels come from a
// tick-count model of the glyph rules, compared by an independent monitor.
module tb_draw_glyph_cell;

    localparam int S  = 10;
    localparam int N  = 8;
    localparam int BF = 3;
    localparam int RF = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  h_counter, v_counter, pos_x, pos_y;
    logic [1:0]  sym;
    logic        frame_tick, blink_en;
    logic [23:0] fg_rgb, bg_rgb;
    logic [7:0]  R, G, B;
    logic        in_box, reveal_done;

    logic        chk_tag, vld1, vld2;
    logic [24:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    int          m_ticks, m_sym, m_start;
    bit          m_active;

    always #5 clk = ~clk;

    draw_glyph_cell #(.SCALE(S), .GLYPH_N(N), .CW(8), .BLINK_FRAMES(BF), .REVEAL_FRAMES(RF)) dut (
        .clk(clk), .reset(reset), .h_counter(h_counter), .v_counter(v_counter),
        .pos_x(pos_x), .pos_y(pos_y), .sym(sym), .frame_tick(frame_tick),
        .blink_en(blink_en), .fg_rgb(fg_rgb), .bg_rgb(bg_rgb),
        .R(R), .G(G), .B(B), .in_box(in_box), .reveal_done(reveal_done)
    );

    function automatic int m_rows();
        int r;
        if (!m_active) return N;
        r = (m_ticks - m_start) / RF;
        return (r > N) ? N : r;
    endfunction

    function automatic bit m_done();
        return m_rows() == N;
    endfunction

    task automatic model_reset();
        m_ticks = 0; m_sym = 0; m_start = 0; m_active = 1'b0;
    endtask

    task automatic model_tick();
        m_ticks++;
        if (int'(sym) != m_sym) begin
            m_sym = int'(sym);
            m_active = (m_sym != 0);
            m_start = m_ticks;
        end
    endtask

    function automatic logic [24:0] model_pix(int h, int v);
        int x0 = int'(pos_x);
        int y0 = int'(pos_y);
        int c, r;
        bit on;
        if (!(h >= x0 && h < x0 + N*S && v >= y0 && v < y0 + N*S)) return {1'b0, bg_rgb};
        c = (h - x0) / S;
        r = (v - y0) / S;
        case (m_sym)
            1:       on = (c == r) || (c == N-1-r);
            2:       on = ((r == 0 || r == N-1) && c >= 1 && c <= N-2) ||
                          ((c == 0 || c == N-1) && r >= 1 && r <= N-2);
            3:       on = (r == 0) || (r == N-1) || (c == 0) || (c == N-1);
            default: on = 1'b0;
        endcase
        on = on && (r < m_rows()) && !(blink_en && ((m_ticks / BF) % 2 == 1));
        return {1'b1, on ? fg_rgb : bg_rgb};
    endfunction

    // Output-valid tag pipeline mirroring the two-cycle latency.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld1 <= 1'b0;
            vld2 <= 1'b0;
        end else begin
            vld1 <= chk_tag;
            vld2 <= vld1;
        end
    end

    // Monitor: pops the scoreboard whenever a tagged pixel reaches the outputs.
    always @(negedge clk) begin
        logic [24:0] e;
        if (reset && vld2) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pixel_underflow got %h want queued entry", {in_box, R, G, B});
            end else begin
                e = exp_q.pop_front();
                if ({in_box, R, G, B} !== e) begin
                    errors++;
                    $display("FAIL pixel got in_box=%b rgb=%h want in_box=%b rgb=%h",
                             in_box, {R, G, B}, e[24], e[23:0]);
                end
            end
        end
    end

    task automatic drive(input int h, input int v, input bit tk, input bit chk);
        h_counter  = 10'(h);
        v_counter  = 10'(v);
        frame_tick = tk;
        chk_tag    = chk;
        if (tk) model_tick();
        if (chk) exp_q.push_back(model_pix(h, v));
        @(posedge clk); #1;
        frame_tick = 1'b0;
        chk_tag    = 1'b0;
        if (tk) begin
            checks++;
            if (reveal_done !== m_done()) begin
                errors++;
                $display("FAIL reveal_done tick=%0d got %b want %b", m_ticks, reveal_done, m_done());
            end
        end
    endtask

    task automatic flush();
        drive(0, 0, 1'b0, 1'b0);
        drive(0, 0, 1'b0, 1'b0);
    endtask

    task automatic set_look(input logic [23:0] fg, input logic [23:0] bg, input logic ben);
        flush();
        fg_rgb = fg; bg_rgb = bg; blink_en = ben;
    endtask

    task automatic check_reset_state(input string tag);
        checks++;
        if ({in_box, R, G, B} !== 25'd0 || reveal_done !== 1'b1) begin
            errors++;
            $display("FAIL %s got in_box=%b rgb=%h done=%b want 0 000000 1",
                     tag, in_box, {R, G, B}, reveal_done);
        end
    endtask

    // One frame: a tick followed by a few random checked pixels in and around the box.
    task automatic frame(input int pix);
        drive(int'(pos_x) + 1, int'(pos_y), 1'b1, 1'b1);
        for (int i = 0; i < pix; i++)
            drive(int'(pos_x) + $urandom_range(0, 89) - 5, int'(pos_y) + $urandom_range(0, 89) - 5, 1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b0; chk_tag = 1'b0; frame_tick = 1'b0; blink_en = 1'b0;
        h_counter = 10'd0; v_counter = 10'd0; pos_x = 10'd100; pos_y = 10'd50;
        sym = 2'd0; fg_rgb = 24'hFF0000; bg_rgb = 24'h000000;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_reset_state("reset_init");
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        // Fixed-colour X reveal then exact pixel probes.
        sym = 2'd1;
        for (int t = 0; t < 17; t++) frame(3);
        drive(100, 50, 1'b0, 1'b1);
        drive(110, 50, 1'b0, 1'b1);
        drive(180, 50, 1'b0, 1'b1);
        drive(179, 129, 1'b0, 1'b1);
        drive(99, 129, 1'b0, 1'b1);
        drive(179, 130, 1'b0, 1'b1);

        // Asynchronous reset mid-line shortly after an in-box pixel.
        drive(100, 50, 1'b0, 1'b0);
        drive(0, 0, 1'b0, 1'b0);
        #3 reset = 1'b0;
        #1 check_reset_state("reset_midline");
        model_reset();
        exp_q.delete();
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        drive(100, 50, 1'b0, 1'b1);
        for (int t = 0; t < 17; t++) frame(2);
        drive(100, 50, 1'b0, 1'b1);

        // O reveal, restart with X at tick 8, mid-frame change invisible until a tick.
        sym = 2'd0; frame(1);
        sym = 2'd2;
        for (int t = 0; t < 5; t++) frame(2);
        drive(124, 50, 1'b0, 1'b1);
        drive(100, 70, 1'b0, 1'b1);
        for (int t = 0; t < 3; t++) frame(2);
        sym = 2'd1;
        for (int t = 0; t < 4; t++) frame(2);
        sym = 2'd3;
        drive(100, 60, 1'b0, 1'b1);
        drive(110, 60, 1'b0, 1'b1);
        for (int t = 0; t < 18; t++) frame(2);

        // Blink on the cursor box.
        set_look(24'h00FF00, 24'h101010, 1'b1);
        for (int t = 0; t < 8; t++) begin
            frame(1);
            drive(100, 50, 1'b0, 1'b1);
        end

        // Right-edge clipping: box from 1000 must not wrap onto h=0..55.
        set_look(24'h0000FF, 24'h202020, 1'b0);
        pos_x = 10'd1000;
        for (int h = 1000; h < 1024; h++) drive(h, 50, 1'b0, 1'b1);
        for (int h = 0; h < 56; h += 5) drive(h, 50, 1'b0, 1'b1);
        pos_x = 10'd100;

        // Randomised scenes.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                set_look(24'($urandom), 24'($urandom), 1'($urandom_range(0, 1)));
                pos_x = 10'($urandom_range(0, 1023));
                pos_y = 10'($urandom_range(0, 1023));
            end
            if ($urandom_range(0, 7) == 0) sym = 2'($urandom_range(0, 3));
            begin
                int hh = int'(pos_x) + $urandom_range(0, 100) - 10;
                int vv = int'(pos_y) + $urandom_range(0, 100) - 10;
                if (hh < 0) hh = 0;
                if (hh > 1023) hh = 1023;
                if (vv < 0) vv = 0;
                if (vv > 1023) vv = 1023;
                drive(hh, vv, ($urandom_range(0, 9) == 0), 1'b1);
            end
        end

        flush();
        drive(0, 0, 1'b0, 1'b0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d leftover want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
